alu_seq: RTL

- Parametrised, multi-cycle successor to the processor's 8-bit combinational ALU.
- Operands and opcode are captured on a START handshake. Single-cycle ops produce a registered result after one cycle. MUL, SLL and SRA run iteratively.
- Provides RESULT, ZERO, CARRY and a BUSY/DONE handshake so the control unit can stall on long operations.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops, iterative MUL/SLL/SRA.
// START/BUSY/DONE handshake lets control stall on long operations.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  localparam logic [SHW-1:0]   WCNT = SHW'(WIDTH);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHW-1:0]       shcnt;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     sh_step;

  assign sum   = {1'b0, DATA1} + {1'b0, DATA2};
  assign diff  = {1'b0, DATA1} - {1'b0, DATA2};
  assign shcnt = (DATA2 >= WLIM) ? WCNT : DATA2[SHW-1:0];

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign sh_step  = (op_q == OP_SLL) ?
                    {sh_q[WIDTH-2:0], 1'b0} :
                    {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          op_d = SELECT;
          unique case (SELECT)
            OP_FWD: begin
              result_d = DATA2;
              carry_d  = 1'b0;
              done_d   = 1'b1;
            end
            OP_ADD: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              done_d   = 1'b1;
            end
            OP_AND: begin
              result_d = DATA1 & DATA2;
              carry_d  = 1'b0;
              done_d   = 1'b1;
            end
            OP_OR: begin
              result_d = DATA1 | DATA2;
              carry_d  = 1'b0;
              done_d   = 1'b1;
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = diff[WIDTH];
              done_d   = 1'b1;
            end
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, DATA1};
              mplier_d = DATA2;
              cnt_d    = WCNT;
              state_d  = RUN;
            end
            OP_SLL, OP_SRA: begin
              if (shcnt == '0) begin
                result_d = DATA1;
                carry_d  = 1'b0;
                done_d   = 1'b1;
              end else begin
                sh_d    = DATA1;
                cnt_d   = shcnt;
                state_d = RUN;
              end
            end
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - SHW'(1);
        if (op_q == OP_MUL) begin
          acc_d    = acc_step;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end else begin
          sh_d = sh_step;
        end
        // last iteration: commit straight from the step value
        if (cnt_q == SHW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (op_q == OP_MUL) begin
            result_d = acc_step[WIDTH-1:0];
            carry_d  = |acc_step[2*WIDTH-1:WIDTH];
          end else begin
            result_d = sh_step;
            carry_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

  assign RESULT = result_q;
  assign ZERO   = (result_q == '0);
  assign CARRY  = carry_q;
  assign BUSY   = (state_q == RUN);
  assign DONE   = done_q;

endmodule
